// File: rtl/wb_commit_checker.sv
// Write-back commit checker: compares retired register writes, in program order,
// against a preloaded table of expected commits and reports pass/fail status.
module wb_commit_checker #(
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned WORD      = 64,
  parameter int unsigned INST_SIZE = 32,
  parameter int unsigned TIMEOUT   = 1000000
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       cfg_we,
  input  logic [$clog2(DEPTH)-1:0]   cfg_addr,
  input  logic [INST_SIZE-1:0]       cfg_inst,
  input  logic [4:0]                 cfg_reg,
  input  logic [WORD-1:0]            cfg_data,
  input  logic [$clog2(DEPTH):0]     cfg_num,
  input  logic                       start,
  input  logic                       wb_valid,
  input  logic [INST_SIZE-1:0]       wb_inst,
  input  logic [4:0]                 wb_reg,
  input  logic [WORD-1:0]            wb_data,
  output logic                       busy,
  output logic                       done,
  output logic                       fail,
  output logic                       err_timeout,
  output logic [$clog2(DEPTH)-1:0]   err_idx,
  output logic [WORD-1:0]            err_data,
  output logic [$clog2(DEPTH):0]     pass_cnt
);

  localparam int unsigned IW = $clog2(DEPTH);
  localparam int unsigned CW = IW + 1;
  localparam int unsigned TW = $clog2(TIMEOUT) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [TW-1:0] TMAX    = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_CHECK, ST_DONE, ST_FAIL} state_t;

  state_t               state, state_nx;
  logic [INST_SIZE-1:0] tab_inst [DEPTH];
  logic [4:0]           tab_reg  [DEPTH];
  logic [WORD-1:0]      tab_data [DEPTH];

  logic [IW-1:0]   idx, idx_nx;
  logic [CW-1:0]   num, num_nx;
  logic [CW-1:0]   cnt, cnt_nx;
  logic [TW-1:0]   timer, timer_nx;
  logic            err_to, err_to_nx;
  logic [IW-1:0]   err_idx_q, err_idx_nx;
  logic [WORD-1:0] err_data_q, err_data_nx;
  logic [CW-1:0]   num_arm;
  logic            trigger, match, last;

  assign trigger = wb_valid && (wb_inst == tab_inst[idx]);
  assign match   = (wb_reg == tab_reg[idx]) && (wb_data == tab_data[idx]);
  assign last    = ({1'b0, idx} + CW'(1)) == num;
  assign num_arm = (cfg_num > DEPTH_C) ? DEPTH_C : cfg_num;

  // Table has no reset; contents are only meaningful once loaded in IDLE.
  always_ff @(posedge clk) begin
    if (cfg_we && state == ST_IDLE) begin
      tab_inst[cfg_addr] <= cfg_inst;
      tab_reg[cfg_addr]  <= cfg_reg;
      tab_data[cfg_addr] <= cfg_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      idx        <= '0;
      num        <= '0;
      cnt        <= '0;
      timer      <= '0;
      err_to     <= 1'b0;
      err_idx_q  <= '0;
      err_data_q <= '0;
    end else begin
      state      <= state_nx;
      idx        <= idx_nx;
      num        <= num_nx;
      cnt        <= cnt_nx;
      timer      <= timer_nx;
      err_to     <= err_to_nx;
      err_idx_q  <= err_idx_nx;
      err_data_q <= err_data_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    idx_nx      = idx;
    num_nx      = num;
    cnt_nx      = cnt;
    timer_nx    = timer;
    err_to_nx   = err_to;
    err_idx_nx  = err_idx_q;
    err_data_nx = err_data_q;
    case (state)
      ST_CHECK: begin
        // A trigger takes priority over a timer that expires in the same cycle.
        if (trigger) begin
          if (match) begin
            cnt_nx   = cnt + CW'(1);
            timer_nx = '0;
            if (last) state_nx = ST_DONE;
            else      idx_nx   = idx + IW'(1);
          end else begin
            state_nx    = ST_FAIL;
            err_to_nx   = 1'b0;
            err_idx_nx  = idx;
            err_data_nx = wb_data;
          end
        end else if (timer == TMAX) begin
          state_nx    = ST_FAIL;
          err_to_nx   = 1'b1;
          err_idx_nx  = idx;
          err_data_nx = '0;
        end else begin
          timer_nx = timer + TW'(1);
        end
      end
      default: begin
        if (start) begin
          num_nx      = num_arm;
          idx_nx      = '0;
          cnt_nx      = '0;
          timer_nx    = '0;
          err_to_nx   = 1'b0;
          err_idx_nx  = '0;
          err_data_nx = '0;
          state_nx    = (num_arm == '0) ? ST_DONE : ST_CHECK;
        end
      end
    endcase
  end

  assign busy        = (state == ST_CHECK);
  assign done        = (state == ST_DONE);
  assign fail        = (state == ST_FAIL);
  assign err_timeout = err_to;
  assign err_idx     = err_idx_q;
  assign err_data    = err_data_q;
  assign pass_cnt    = cnt;

endmodule

// File: doc/wb_commit_checker.md
# wb_commit_checker

Synthesizable write-back commit checker that sits directly downstream of the CPU's WB stage, in both SingleCycleTOP and PipelineTOP builds. It consumes every retired register write (instruction, destination register, write data) and checks it, in program order, against a table of expected commits loaded before the run. It reports pass/fail, the failing entry, and a commit count, so sort and factorial programs self-check in simulation and on FPGA without testbench hierarchy probes.

## Interface
Parameters:
- DEPTH, 8: number of expected-commit entries.
- WORD, 64: data width (matches `WORD).
- INST_SIZE, 32: instruction width (matches `INST_SIZE).
- TIMEOUT, 1000000: max cycles between matched triggers before failing.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- cfg_we  in  1  table write strobe; accepted only in IDLE.
- cfg_addr  in  $clog2(DEPTH)  table entry index.
- cfg_inst  in  INST_SIZE  expected trigger instruction.
- cfg_reg  in  5  expected destination register.
- cfg_data  in  WORD  expected write data.
- cfg_num  in  $clog2(DEPTH)+1  number of valid entries; sampled on start.
- start  in  1  one-cycle pulse; arms the checker from IDLE.
- wb_valid  in  1  WB stage retires a register write this cycle.
- wb_inst  in  INST_SIZE  instruction being retired.
- wb_reg  in  5  destination register of the retired write.
- wb_data  in  WORD  data written back.
- busy  out  1  checker armed (CHECK state).
- done  out  1  sticky; all entries matched.
- fail  out  1  sticky; mismatch or timeout.
- err_timeout  out  1  fail cause: 1 = timeout, 0 = mismatch.
- err_idx  out  $clog2(DEPTH)  entry index at failure.
- err_data  out  WORD  wb_data captured at mismatch (0 on timeout).
- pass_cnt  out  $clog2(DEPTH)+1  entries matched so far.

## Operation
- States: IDLE, CHECK, DONE, FAIL. Reset → IDLE; all outputs 0, idx 0, timer 0, table contents undefined.
- IDLE: cfg_we writes {cfg_inst, cfg_reg, cfg_data} into entry cfg_addr. On start: latch num ← cfg_num, clear idx, pass_cnt, timer, err_*; if num = 0 → DONE, else → CHECK.
- CHECK: each cycle with wb_valid and wb_inst == table[idx].inst is a trigger:
  - wb_reg == table[idx].reg and wb_data == table[idx].data → pass_cnt+1, idx+1, timer cleared; if idx+1 == num → DONE.
  - otherwise → FAIL, err_timeout 0, err_idx ← idx, err_data ← wb_data.
- Commits with wb_valid 0, or whose instruction is not the current trigger, are ignored; only table[idx] is compared (in-order matching; later entries are never matched early).
- Timer increments every CHECK cycle without a trigger; reaching TIMEOUT-1 → FAIL, err_timeout 1, err_idx ← idx, err_data ← 0.
- DONE / FAIL: terminal; only start (re-arm, same as from IDLE, with table reused) or reset leaves them. cfg_we is ignored outside IDLE.
- cfg_num > DEPTH is clamped to DEPTH.

## Timing
- All outputs registered; a trigger in cycle N is reflected in pass_cnt/done/fail/err_* after the rising edge ending cycle N (visible in N+1).
- start in cycle N: busy = 1 from N+1 (or done = 1 from N+1 if num = 0).
- A trigger in the same cycle that the timer expires counts as the trigger (compare wins over timeout).
- start while busy is ignored.
- Reset asserted mid-run: immediate return to IDLE, outputs cleared asynchronously; table need not be preserved.

## Test plan
- Sort sequence: load 5 entries (f8400009/x9/0x1, f8408009/x9/0x2, f8410009/x9/0x27, f8418009/x9/0x45, f8420009/x9/0x99), num 5, start, replay the commits with unrelated commits interleaved → done = 1 and pass_cnt = 5 one cycle after the fifth trigger; fail stays 0.
- Mismatch: same table, third trigger commits data 0x28 → fail = 1, err_timeout 0, err_idx 2, err_data 0x28, pass_cnt 2; later correct commits leave these unchanged.
- Wrong register: first trigger retires to x10 with data 0x1 → fail, err_idx 0.
- Timeout: TIMEOUT 100, one entry, never commit its trigger → fail and err_timeout = 1 exactly 100 cycles after busy rises.
- Edge cases: start with num 0 → done next cycle; cfg_we during CHECK leaves the table unchanged (verify by re-arming); reset pulse mid-CHECK → all outputs 0 and state IDLE.
- Factorial: single entry with the final-result instruction, expected data 0x21C3677C82B40000 → done = 1.
